ovo_vote_scheduler: RTL and testbench
=====================================

# ovo_vote_scheduler

Sequencer for one-vs-one multiclass SVM inference over a single shared sequential `binarySVM` datapath. It walks every class pair (i, j) in a fixed order and drives the pairwise-SVM index that selects weights and bias. It launches each pairwise evaluation, tallies per-class votes from the binary decision, and reports the arg-max class. It sits between the top-level inference handshake and the shared binary SVM, replacing fixed picker sequencing with a start/done-controlled scheduler.

## Interface
Parameters:
- `N_CLASSES`, 10, number of classes; must be ≥ 2
- `IDX_W`, 6, width of pairwise-SVM index; must satisfy 2^IDX_W ≥ N_CLASSES·(N_CLASSES−1)/2
- `CLS_W`, 4, width of class index; must satisfy 2^CLS_W ≥ N_CLASSES

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one inference; sampled only in IDLE
- `busy`  out  1  high from the cycle after accepted start through DONE
- `svm_idx`  out  IDX_W  current pairwise-SVM index (weight/bias select)
- `svm_start`  out  1  one-cycle launch pulse to binary SVM
- `svm_ready`  in  1  one-cycle result-valid pulse from binary SVM
- `svm_class`  in  1  pairwise decision: 1 = vote class i, 0 = vote class j
- `done`  out  1  one-cycle pulse, `winner` valid
- `winner`  out  CLS_W  arg-max class; held until next `done`

## Operation
- Pair order: i = 0..N−2 outer, j = i+1..N−1 inner; `svm_idx` = 0,1,2,… in that order, with last index N(N−1)/2 − 1 (44 for N=10).
- Vote counters: N counters, each ceil(log2(N)) bits, saturation never needed (max N−1).
- FSM states:
  - IDLE: counters idle. `start` clears votes, sets i=0, j=1, idx=0, and goes to ISSUE.
  - ISSUE: `svm_start`=1 for exactly one cycle, then WAIT.
  - WAIT: hold `svm_idx` stable. On `svm_ready`, go to TALLY.
  - TALLY: increment votes[i] if captured `svm_class`=1, otherwise votes[j]. If the pair was last, go to ARGMAX; otherwise advance (i,j,idx) and go to ISSUE.
  - ARGMAX: scan classes 0..N−1, one per cycle. Strict greater-than compare, so on ties the lowest index wins. After N cycles go to DONE.
  - DONE: register `winner`, pulse `done`, return to IDLE.
- `svm_class` is captured in the WAIT cycle where `svm_ready`=1.
- `start` while not IDLE is ignored. `svm_ready` outside WAIT is ignored.
- `start` in the same cycle as `done` (DONE state) is ignored; it is accepted from IDLE only.

## Timing
- Reset values: `busy`=0, `svm_start`=0, `done`=0, `svm_idx`=0, `winner`=0, all votes 0, state IDLE.
- Reset mid-operation aborts immediately, with no `done` pulse.
- `svm_idx` is valid in the ISSUE cycle and stays constant until TALLY.
- With binary-SVM latency L cycles from `svm_start` to `svm_ready`, total latency from `start` to `done` = 1 + P·(L+2) + N + 1, where P = N(N−1)/2.
- A `svm_ready` arriving in the same cycle as `svm_start` is not legal and is not captured.

## Configuration
- `OVO_EARLY_EXIT_EN` defined: in TALLY, if the incremented counter reaches N−1, skip all remaining pairs and ARGMAX, set `winner` to that class, and go to DONE next cycle. A class with N−1 votes cannot be beaten or tied.
- `OVO_EARLY_EXIT_EN` undefined: all P pairs are always evaluated. Latency is fixed per the Timing formula.

## Structure
- Package `svm_sched_pkg` holds:
  - state enum `sched_state_t` (IDLE, ISSUE, WAIT, TALLY, ARGMAX, DONE)
  - helper function `n_pairs(n)`
  - vote width constant function
- Sub-module `ovo_pair_counter` holds the (i, j, idx) generator, with clear/advance inputs and a `last` output. The top FSM instantiates it once.

## Test plan
- Reset, then `start`, with a model where class 3 wins every pair it is in and others use i-wins. Required: 45 `svm_start` pulses with idx 0..44 in order, then `done` with `winner`=3; `busy` falls after `done`.
- All `svm_class`=1 with fixed L=2: `winner`=0, and `done` arrives exactly 1+45·4+10+1 = 192 cycles after `start`.
- Tie: stimulus gives classes 2 and 7 equal maximum votes. Required: `winner`=2.
- `rst` asserted during WAIT at pair 20. Required: next cycle all outputs at reset values and no `done`. A following `start` restarts at idx 0.
- `start` pulsed during WAIT, and spurious `svm_ready` during TALLY/ARGMAX: both ignored, and vote totals still sum to 45.
- With `OVO_EARLY_EXIT_EN`, class 0 wins all of its pairs: `done` after idx 8 (9 pairs) with `winner`=0. Without the macro, same stimulus: all 45 pairs run.

Source files
------------

// File: rtl/ovo_vote_scheduler_pkg.sv
// svm_sched_pkg: shared types and sizing helpers for the one-vs-one vote scheduler
package svm_sched_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, TALLY, ARGMAX, DONE} sched_state_t;
    function automatic int n_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction
    function automatic int vote_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ovo_vote_scheduler_if.sv
// ovo_vote_scheduler_if: inference handshake plus binary-SVM launch/result signals
interface ovo_vote_scheduler_if #(parameter int IDX_W = 6, parameter int CLS_W = 4);
    logic             start;
    logic             busy;
    logic [IDX_W-1:0] svm_idx;
    logic             svm_start;
    logic             svm_ready;
    logic             svm_class;
    logic             done;
    logic [CLS_W-1:0] winner;
    modport master (output start, svm_ready, svm_class, input busy, svm_idx, svm_start, done, winner);
    modport slave (input start, svm_ready, svm_class, output busy, svm_idx, svm_start, done, winner);
endinterface

// File: rtl/ovo_vote_scheduler_pair_counter.sv
// ovo_pair_counter: walks class pairs (i, j) with i outer, j inner, and their linear index
module ovo_pair_counter
    import svm_sched_pkg::*;
#(
    parameter int N_CLASSES = 10,
    parameter int IDX_W = 6,
    parameter int CLS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [CLS_W-1:0] o_i,
    output logic [CLS_W-1:0] o_j,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);
    logic [CLS_W-1:0] r_i, r_j;
    logic [IDX_W-1:0] r_idx;

    // restart at pair (0,1) on clear, otherwise step j and wrap into the next row
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_i <= '0;
            r_j <= CLS_W'(1);
            r_idx <= '0;
        end else if (i_advance) begin
            r_i <= (r_j == CLS_W'(N_CLASSES - 1)) ? r_i + CLS_W'(1) : r_i;
            r_j <= (r_j == CLS_W'(N_CLASSES - 1)) ? r_i + CLS_W'(2) : r_j + CLS_W'(1);
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign o_i = r_i;
    assign o_j = r_j;
    assign o_idx = r_idx;
    assign o_last = r_idx == IDX_W'(n_pairs(N_CLASSES) - 1);
endmodule

// File: rtl/ovo_vote_scheduler.sv
// ovo_vote_scheduler: one-vs-one SVM vote sequencer over a shared binary SVM; OVO_EARLY_EXIT_EN ends early on an unbeatable class
module ovo_vote_scheduler
    import svm_sched_pkg::*;
#(
    parameter int N_CLASSES = 10,
    parameter int IDX_W = 6,
    parameter int CLS_W = 4
) (
    input logic clk,
    input logic rst,
    ovo_vote_scheduler_if.slave bus
);
    localparam int VW = vote_w(N_CLASSES);

    sched_state_t     r_state;
    logic [VW-1:0]    r_votes [N_CLASSES];
    logic [VW-1:0]    r_best_cnt;
    logic [CLS_W-1:0] r_scan, r_best, r_winner;
    logic             r_cls, r_busy, r_svm_start, r_done;
    logic [CLS_W-1:0] w_i, w_j, w_inc, w_next_best;
    logic [VW-1:0]    w_inc_cnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_clear, w_adv, w_last, w_take, w_early;

    ovo_pair_counter #(.N_CLASSES(N_CLASSES), .IDX_W(IDX_W), .CLS_W(CLS_W)) u_pairs (
        .clk(clk),
        .rst(rst),
        .i_clear(w_clear),
        .i_advance(w_adv),
        .o_i(w_i),
        .o_j(w_j),
        .o_idx(w_idx),
        .o_last(w_last)
    );

    assign w_clear = r_state == IDLE && bus.start;
    assign w_inc = r_cls ? w_i : w_j;
    assign w_inc_cnt = r_votes[w_inc] + VW'(1);
    assign w_take = r_votes[r_scan] > r_best_cnt;
    assign w_next_best = w_take ? r_scan : r_best;
`ifdef OVO_EARLY_EXIT_EN
    assign w_early = w_inc_cnt == VW'(N_CLASSES - 1);
`else
    assign w_early = 1'b0;
`endif
    assign w_adv = r_state == TALLY && !w_last && !w_early;

    // scheduler FSM: issue each pair, wait for the decision, tally it, then scan for the arg-max
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy <= 1'b0;
            r_svm_start <= 1'b0;
            r_done <= 1'b0;
            r_winner <= '0;
            r_cls <= 1'b0;
            r_scan <= '0;
            r_best <= '0;
            r_best_cnt <= '0;
            for (int k = 0; k < N_CLASSES; k++) r_votes[k] <= '0;
        end else begin
            r_svm_start <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    for (int k = 0; k < N_CLASSES; k++) r_votes[k] <= '0;
                    r_busy <= 1'b1;
                    r_svm_start <= 1'b1;
                    r_state <= ISSUE;
                end
                ISSUE: r_state <= WAIT;
                WAIT: if (bus.svm_ready) begin
                    r_cls <= bus.svm_class;
                    r_state <= TALLY;
                end
                TALLY: begin
                    r_votes[w_inc] <= w_inc_cnt;
                    if (w_early) begin
                        r_winner <= w_inc;
                        r_done <= 1'b1;
                        r_state <= DONE;
                    end else if (w_last) begin
                        r_scan <= '0;
                        r_best <= '0;
                        r_best_cnt <= '0;
                        r_state <= ARGMAX;
                    end else begin
                        r_svm_start <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ARGMAX: begin
                    r_best <= w_next_best;
                    r_best_cnt <= w_take ? r_votes[r_scan] : r_best_cnt;
                    r_scan <= r_scan + CLS_W'(1);
                    if (r_scan == CLS_W'(N_CLASSES - 1)) begin
                        r_winner <= w_next_best;
                        r_done <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.svm_idx = w_idx;
    assign bus.svm_start = r_svm_start;
    assign bus.done = r_done;
    assign bus.winner = r_winner;
endmodule

// File: tb/tb_ovo_vote_scheduler.sv
// tb_ovo_vote_scheduler: randomized vote stimulus against a pairwise-tally reference model
module tb_ovo_vote_scheduler;
    localparam int N = 10;
    localparam int P = N * (N - 1) / 2;
`ifdef OVO_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int pi [P];
    int pj [P];
    bit dec [P];
    int lat [P];

    ovo_vote_scheduler_if #(.IDX_W(6), .CLS_W(4)) bus ();
    ovo_vote_scheduler #(.N_CLASSES(N), .IDX_W(6), .CLS_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // decisions per pair: 0 random, 1 class 3 always wins else i, 2 always i, 3 tie 2/7, 4 class 0 always wins else random
    task automatic set_dec(input int pol);
        for (int k = 0; k < P; k++) begin
            int a = pi[k];
            int b = pj[k];
            case (pol)
                1: dec[k] = (a == 3) ? 1'b1 : (b == 3) ? 1'b0 : 1'b1;
                2: dec[k] = 1'b1;
                3: dec[k] = (a == 2 || a == 0 && b == 2) ? 1'b1 : (b == 2) ? 1'b0 : (a == 7) ? 1'b1 : 1'b0;
                4: dec[k] = (a == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                default: dec[k] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic set_lat(input int fixed);
        for (int k = 0; k < P; k++) lat[k] = (fixed > 0) ? fixed : int'($urandom_range(1, 4));
    endtask

    // plain vote tally over the evaluated pairs; lowest class wins ties
    task automatic model(output int pairs, output int win, output bit hit);
        int v [N];
        for (int c = 0; c < N; c++) v[c] = 0;
        pairs = P;
        hit = 1'b0;
        win = 0;
        for (int k = 0; k < P; k++) begin
            int w = dec[k] ? pi[k] : pj[k];
            v[w]++;
            if (EARLY && v[w] == N - 1) begin
                pairs = k + 1;
                win = w;
                hit = 1'b1;
                return;
            end
        end
        for (int c = 1; c < N; c++) if (v[c] > v[win]) win = c;
    endtask

    task automatic run(input bit noise, input int abort_at);
        int n, k, ready_at, issue_at, done_at, exp_pairs, exp_win, exp_lat, dones;
        bit hit, cur;
        model(exp_pairs, exp_win, hit);
        exp_lat = 2 + (hit ? 0 : N);
        for (int q = 0; q < exp_pairs; q++) exp_lat += lat[q] + 2;
        @(negedge clk);
        bus.start = 1'b1;
        n = 0;
        k = 0;
        ready_at = -10;
        issue_at = -10;
        done_at = -1;
        cur = 1'b0;
        while (done_at < 0 && n < 2000) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            bus.svm_ready = 1'b0;
            bus.svm_class = 1'b0;
            if (n == 1) chk("busy_on", bus.busy, 1);
            if (bus.done) done_at = n;
            if (bus.svm_start) begin
                if (k < P) begin
                    chk($sformatf("idx%0d", k), bus.svm_idx, k);
                    ready_at = n + lat[k];
                    cur = dec[k];
                end
                issue_at = n;
                k++;
                if (k - 1 == abort_at) begin
                    @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    chk("abort_busy", bus.busy, 0);
                    chk("abort_svm_start", bus.svm_start, 0);
                    chk("abort_done", bus.done, 0);
                    chk("abort_idx", bus.svm_idx, 0);
                    chk("abort_winner", bus.winner, 0);
                    rst = 1'b0;
                    dones = 0;
                    for (int c = 0; c < 20; c++) begin
                        @(negedge clk);
                        dones += int'(bus.done);
                    end
                    chk("abort_no_done", dones, 0);
                    return;
                end
            end
            if (n == ready_at) begin
                bus.svm_ready = 1'b1;
                bus.svm_class = cur;
            end else if (noise && done_at < 0 && (n == ready_at + 1 || k == exp_pairs && n > ready_at + 1)) begin
                bus.svm_ready = 1'($urandom_range(0, 1));
                bus.svm_class = 1'($urandom_range(0, 1));
            end
            if (noise && n == ready_at - 1 && n > issue_at) bus.start = 1'b1;
        end
        chk("done_seen", done_at > 0, 1);
        chk("launches", k, exp_pairs);
        chk("winner", bus.winner, exp_win);
        chk("busy_at_done", bus.busy, 1);
        // the latency formula counts the start cycle itself through the done cycle
        chk("latency", done_at + 1, exp_lat);
        @(negedge clk);
        bus.svm_ready = 1'b0;
        chk("done_pulse", bus.done, 0);
        chk("busy_off", bus.busy, 0);
        chk("winner_held", bus.winner, exp_win);
    endtask

    initial begin
        int q = 0;
        for (int a = 0; a < N - 1; a++)
            for (int b = a + 1; b < N; b++) begin
                pi[q] = a;
                pj[q] = b;
                q++;
            end
        bus.start = 1'b0;
        bus.svm_ready = 1'b0;
        bus.svm_class = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_svm_start", bus.svm_start, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_idx", bus.svm_idx, 0);
        chk("rst_winner", bus.winner, 0);
        rst = 1'b0;
        set_dec(1); set_lat(0); run(1'b0, -1);
        set_dec(2); set_lat(2); run(1'b0, -1);
        set_dec(3); set_lat(0); run(1'b0, -1);
        set_dec(1); set_lat(3); run(1'b0, 20);
        set_dec(0); set_lat(0); run(1'b0, -1);
        set_dec(0); set_lat(0); run(1'b1, -1);
        set_dec(4); set_lat(0); run(1'b0, -1);
        for (int r = 0; r < 4; r++) begin
            set_dec(0);
            set_lat(0);
            run(1'($urandom_range(0, 1)), -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
